adc0809_model: RTL and testbench
================================

# adc0809_model

Synthesizable responder model of the ADC0809CCN 8-channel, 8-bit converter, driven by a single system clock. It answers the ALE/START/EOC/OE handshake that the ADC controller issues. It returns a snapshot of per-channel sample values supplied by the testbench. It sits on the bench side of the ADC interface: its outputs connect to the controller's `eoc` and `data_in`, and its inputs take the controller's `ale`, `start` and `oe`.

## Interface
Parameters:
- CONV_CYCLES, 64: number of clk cycles `eoc` is held low per conversion (>=1).
- EOC_DLY, 2: clk cycles from START falling edge to `eoc` going low (>=1).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- ale  input  1  address latch enable; `addr` captured every cycle `ale`=1.
- addr  input  3  channel select (ADDC..ADDA); 3'b011 = IN3.
- start  input  1  conversion start; rising edge arms, falling edge starts.
- oe  input  1  output enable.
- ch_data  input  64  channel sample values; channel n = ch_data[8n+7:8n].
- eoc  output  1  end of conversion; low while converting.
- data_out  output  8  conversion result while enabled, else 8'h00.
- data_drv  output  1  1 when `data_out` is being driven (registered copy of `oe`).
- conv_count  output  16  number of completed conversions, wraps at 16'hFFFF->0.
- early_oe  output  1  sticky flag; set if `oe`=1 while `eoc`=0.

## Operation
- Edge detection: `start_q` is `start` registered each clk. Rise = start & ~start_q; fall = ~start & start_q.
- Address latch: `addr_q` <= `addr` on every cycle with `ale`=1. Otherwise it holds.
- States:
  - IDLE: `eoc`=1.
  - ARMED: `eoc`=1; waiting for the START fall.
  - DELAY: `eoc`=1; counts EOC_DLY cycles.
  - CONVERT: `eoc`=0; counts CONV_CYCLES cycles.
  - DONE: `eoc`=1; result valid.
- Transitions:
  - Any state, START rise -> ARMED. This aborts an in-progress conversion; the result is not updated and conv_count is not incremented.
  - ARMED, START fall -> DELAY, counter cleared.
  - DELAY, after EOC_DLY cycles -> CONVERT. On that entry cycle, `snap` <= ch_data[8*addr_q +: 8]. The snapshot uses `addr_q` as it stands at that cycle.
  - CONVERT, after CONV_CYCLES cycles -> DONE. `result` <= `snap`; conv_count increments.
  - DONE -> stays until the next START rise.
  - IDLE -> stays until a START rise.
- Output path, registered:
  - `data_out` <= oe ? result : 8'h00.
  - `data_drv` <= oe.
  - `oe` works in every state. In CONVERT it returns the previous result.
- early_oe: set on any cycle with oe=1 and state=CONVERT. It clears only on reset.
- Changing `ch_data` after the snapshot has no effect on the current conversion.

## Timing
- Reset values: eoc=1, data_out=8'h00, data_drv=0, conv_count=0, early_oe=0. Internal: state=IDLE, addr_q=0, result=0, snap=0, start_q=0, counters=0.
- Reset during any state returns to IDLE on the next clk. The pending result is discarded.
- START rise is detected one clk after `start` goes high (start_q latency). The same applies to the fall.
- START fall sampled at clk k -> `eoc` goes low at clk k+EOC_DLY. It stays low for exactly CONV_CYCLES clks, then returns high with `result` updated in the same cycle.
- `oe` -> `data_out`/`data_drv` latency is 1 clk.
- If START rise and fall would both be detected in one cycle (impossible with one-bit history), rise has priority. A start pulse must be high for at least 1 clk to register.
- A START pulse held high indefinitely keeps the block in ARMED with eoc=1.

## Test plan
- Basic IN3 conversion: ch_data channel 3 = 8'hA5, ale pulse with addr=3'b011, 1-clk start pulse, EOC_DLY=2, CONV_CYCLES=64. Required: eoc low exactly 64 clks, beginning 2 clks after the fall; then oe=1 -> data_out=8'hA5 one clk later, data_drv=1; conv_count=1.
- Channel select: ch_data[n] = 8'h10+n; convert channels 0..7 in sequence. Required: data_out = 8'h10..8'h17 in order; conv_count=8.
- Snapshot: change channel 3 from 8'h33 to 8'hCC mid-CONVERT. Required: result 8'h33; the next conversion returns 8'hCC.
- Abort: START rise at clk 20 of CONVERT. Required: eoc returns high in ARMED; result and conv_count unchanged; after the fall, a full conversion runs.
- Early read: assert oe during CONVERT. Required: early_oe=1 and sticky, data_out = previous result; reset clears it.
- Reset mid-conversion: drop rst_n for 1 clk during CONVERT. Required: all outputs at reset values next clk; eoc=1.

Source files
------------

// File: rtl/adc0809_model.sv
// rtl/adc0809_model.sv - ADC0809 responder model answering the ALE/START/EOC/OE handshake
// Returns a per-channel snapshot taken as the conversion begins.
module adc0809_model #(
  parameter int CONV_CYCLES = 64,
  parameter int EOC_DLY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ale,
  input  logic [2:0]  addr,
  input  logic        start,
  input  logic        oe,
  input  logic [63:0] ch_data,
  output logic        eoc,
  output logic [7:0]  data_out,
  output logic        data_drv,
  output logic [15:0] conv_count,
  output logic        early_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_CONVERT,
    S_DONE
  } state_t;

  localparam logic [15:0] DLY_LAST  = 16'(EOC_DLY - 1);
  localparam logic [15:0] CONV_LAST = 16'(CONV_CYCLES - 1);

  state_t      state;
  logic        start_q;
  logic [2:0]  addr_q;
  logic [7:0]  snap;
  logic [7:0]  result;
  logic [15:0] cnt;
  logic        start_rise;
  logic        start_fall;

  assign start_rise = start & ~start_q;
  assign start_fall = ~start & start_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      start_q    <= 1'b0;
      addr_q     <= 3'd0;
      snap       <= 8'h00;
      result     <= 8'h00;
      cnt        <= 16'd0;
      eoc        <= 1'b1;
      data_out   <= 8'h00;
      data_drv   <= 1'b0;
      conv_count <= 16'd0;
      early_oe   <= 1'b0;
    end else begin
      start_q  <= start;
      data_out <= oe ? result : 8'h00;
      data_drv <= oe;
      if (ale) addr_q <= addr;
      if (oe && state == S_CONVERT) early_oe <= 1'b1;

      // A rising START wins over every other transition, including an active conversion.
      if (start_rise) begin
        state <= S_ARMED;
        eoc   <= 1'b1;
        cnt   <= 16'd0;
      end else begin
        case (state)
          S_ARMED: begin
            if (start_fall) begin
              state <= S_DELAY;
              cnt   <= 16'd0;
            end
          end
          S_DELAY: begin
            if (cnt == DLY_LAST) begin
              state <= S_CONVERT;
              eoc   <= 1'b0;
              cnt   <= 16'd0;
              snap  <= ch_data[{addr_q, 3'b000} +: 8];
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_CONVERT: begin
            if (cnt == CONV_LAST) begin
              state      <= S_DONE;
              eoc        <= 1'b1;
              cnt        <= 16'd0;
              result     <= snap;
              conv_count <= conv_count + 16'd1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc0809_model.sv
// tb/tb_adc0809_model.sv - directed self-checking bench for adc0809_model
module tb_adc0809_model;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ale;
  logic [2:0]  addr;
  logic        start;
  logic        oe;
  logic [63:0] ch_data;
  logic        eoc;
  logic [7:0]  data_out;
  logic        data_drv;
  logic [15:0] conv_count;
  logic        early_oe;

  int n_vec = 0;
  int n_bad = 0;

  adc0809_model #(.CONV_CYCLES(64), .EOC_DLY(2)) dut (
    .clk(clk), .rst_n(rst_n), .ale(ale), .addr(addr), .start(start), .oe(oe),
    .ch_data(ch_data), .eoc(eoc), .data_out(data_out), .data_drv(data_drv),
    .conv_count(conv_count), .early_oe(early_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_eoc(input logic lvl, input int budget);
    int n = 0;
    while (eoc !== lvl && n < budget) begin
      tick();
      n++;
    end
    if (eoc !== lvl) check("eoc_timeout", 32'(eoc), 32'(lvl));
  endtask

  // Latch channel, pulse START for one clk, leave the block converting.
  task automatic begin_conv(input logic [2:0] ch);
    ale = 1'b1; addr = ch; tick();
    ale = 1'b0; start = 1'b1; tick();
    start = 1'b0; tick();
    wait_eoc(1'b0, 10);
  endtask

  task automatic run_conv(input logic [2:0] ch);
    begin_conv(ch);
    wait_eoc(1'b1, 100);
  endtask

  task automatic read_check(input string tag, input logic [7:0] exp);
    oe = 1'b1; tick();
    check(tag, 32'(data_out), 32'(exp));
    check({tag, "_drv"}, 32'(data_drv), 32'd1);
    oe = 1'b0; tick();
  endtask

  int lows;

  initial begin
    rst_n = 1'b0; ale = 1'b0; addr = 3'd0; start = 1'b0; oe = 1'b0; ch_data = '0;
    tick(); tick();
    check("rst_eoc", 32'(eoc), 32'd1);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_drv", 32'(data_drv), 32'd0);
    check("rst_cnt", 32'(conv_count), 32'd0);
    check("rst_early", 32'(early_oe), 32'd0);
    rst_n = 1'b1;

    // Basic IN3 conversion with exact EOC timing.
    ch_data[31:24] = 8'hA5;
    ale = 1'b1; addr = 3'b011; tick();
    ale = 1'b0; start = 1'b1; tick();
    start = 1'b0; tick();
    check("dly0_eoc", 32'(eoc), 32'd1);
    tick();
    check("dly1_eoc", 32'(eoc), 32'd1);
    tick();
    check("conv_eoc", 32'(eoc), 32'd0);
    lows = 1;
    while (eoc === 1'b0 && lows < 200) begin
      tick();
      if (eoc === 1'b0) lows++;
    end
    check("eoc_low_len", 32'(lows), 32'd64);
    check("basic_cnt", 32'(conv_count), 32'd1);
    check("idle_data", 32'(data_out), 32'h0);
    read_check("basic_data", 8'hA5);
    check("drv_off", 32'(data_drv), 32'd0);

    // Channel select sweep.
    do_reset();
    for (int n = 0; n < 8; n++) ch_data[8*n +: 8] = 8'h10 + 8'(n);
    for (int n = 0; n < 8; n++) begin
      run_conv(3'(n));
      read_check($sformatf("chan%0d", n), 8'h10 + 8'(n));
    end
    check("sweep_cnt", 32'(conv_count), 32'd8);

    // Snapshot: a change after conversion start is ignored until the next one.
    ch_data[31:24] = 8'h33;
    begin_conv(3'd3);
    repeat (10) tick();
    ch_data[31:24] = 8'hCC;
    wait_eoc(1'b1, 100);
    read_check("snap_old", 8'h33);
    run_conv(3'd3);
    read_check("snap_new", 8'hCC);
    check("snap_cnt", 32'(conv_count), 32'd10);

    // Abort at clk 20 of CONVERT.
    ch_data[15:8] = 8'h5E;
    begin_conv(3'd1);
    repeat (20) tick();
    start = 1'b1; tick();
    check("abort_eoc", 32'(eoc), 32'd1);
    check("abort_cnt", 32'(conv_count), 32'd10);
    read_check("abort_data", 8'hCC);
    check("armed_eoc", 32'(eoc), 32'd1);
    start = 1'b0; tick(); tick();
    wait_eoc(1'b0, 10);
    lows = 1;
    while (eoc === 1'b0 && lows < 200) begin
      tick();
      if (eoc === 1'b0) lows++;
    end
    check("rerun_len", 32'(lows), 32'd64);
    check("rerun_cnt", 32'(conv_count), 32'd11);
    read_check("rerun_data", 8'h5E);

    // Early read during CONVERT returns previous result and sets the sticky flag.
    ch_data[55:48] = 8'h77;
    begin_conv(3'd6);
    check("early_pre", 32'(early_oe), 32'd0);
    oe = 1'b1; tick();
    check("early_data", 32'(data_out), 32'h5E);
    check("early_set", 32'(early_oe), 32'd1);
    oe = 1'b0;
    wait_eoc(1'b1, 100);
    check("early_sticky", 32'(early_oe), 32'd1);
    read_check("early_after", 8'h77);

    // Reset mid-conversion.
    oe = 1'b1;
    begin_conv(3'd6);
    repeat (5) tick();
    rst_n = 1'b0; tick();
    check("mid_rst_eoc", 32'(eoc), 32'd1);
    check("mid_rst_data", 32'(data_out), 32'h0);
    check("mid_rst_drv", 32'(data_drv), 32'd0);
    check("mid_rst_cnt", 32'(conv_count), 32'd0);
    check("mid_rst_early", 32'(early_oe), 32'd0);
    rst_n = 1'b1; oe = 1'b0;
    repeat (70) tick();
    check("post_rst_eoc", 32'(eoc), 32'd1);
    read_check("post_rst_data", 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
